uart_word_packer: RTL

Packs the byte stream from the UART receiver into DATA_WIDTH-bit words and writes them into the write-side of the UART-to-DDR FIFO. This FIFO is drained in bursts by the AXI write master. The block holds one word being accumulated and one word waiting for the FIFO, so byte reception continues while the FIFO is briefly full. Loss is detected and flagged, never silent.

---
 rtl/uart_word_packer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_word_packer.sv
// Purpose     : packs UART receive bytes (little-endian lanes) into DATA_WIDTH-bit words for the UART-to-DDR FIFO.
// Latency     : the last byte of a word is sampled at edge N; with the output free and the FIFO not full, o_fifo_wr_en is high in the cycle after N.
// Backpressure: none toward the UART. One accumulator word plus one output word absorb a full FIFO; bytes arriving while both are occupied are dropped and flagged on o_overflow.
//
// Ports:
//   i_clk, i_rst       clock; synchronous active-high reset
//   i_rx_data/valid    byte stream from the UART receiver (one-cycle strobe per byte)
//   i_fifo_full        write-side full flag of the downstream FIFO
//   o_fifo_wr_en/data  FIFO write strobe and word
//   o_overflow         sticky: at least one byte has been dropped since reset
//   o_byte_cnt         bytes currently held in the accumulator (0..BYTES)
//   o_states           debug {acc_full, out_pending}
//
// Optional feature: define UART_PACKER_TIMEOUT_FLUSH_EN to zero-pad and flush a partial word
// after TIMEOUT_CYCLES idle cycles. Without it, a partial word waits until it is filled.

module uart_word_packer #(
    parameter int DATA_WIDTH     = 256,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [7:0]                        i_rx_data,
    input  logic                              i_rx_valid,
    input  logic                              i_fifo_full,
    output logic                              o_fifo_wr_en,
    output logic [DATA_WIDTH-1:0]             o_fifo_data,
    output logic                              o_overflow,
    output logic [$clog2(DATA_WIDTH/8):0]     o_byte_cnt,
    output logic [1:0]                        o_states
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CW    = $clog2(BYTES) + 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t CNT_FULL = cnt_t'(BYTES);
    localparam cnt_t CNT_LAST = cnt_t'(BYTES - 1);

    // Output register occupancy.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_HOLD  = 1'b1
    } out_state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] acc_q,   acc_d;
    logic [DATA_WIDTH-1:0] out_q,   out_d;
    cnt_t                  cnt_q,   cnt_d;
    out_state_e            state_q, state_d;
    logic                  ovf_q,   ovf_d;

`ifdef UART_PACKER_TIMEOUT_FLUSH_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    typedef logic [IW-1:0] idle_t;
    localparam idle_t IDLE_LAST = idle_t'(TIMEOUT_CYCLES - 1);

    idle_t idle_q, idle_d;
    logic  partial;
`endif

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic acc_full;   // accumulator holds a complete word (registered view)
    logic wr_en;      // FIFO write this cycle
    logic out_free;   // output register can take a word at this edge
    logic accept;     // byte stored this edge
    logic drop;       // byte lost this edge
    logic last_byte;  // accepted byte completes the word
    logic flush;      // idle timeout pads out a partial word
    logic acc_done;   // accumulator word is ready to move at this edge
    logic xfer;       // accumulator -> output move at this edge

    always_comb begin
        acc_full = (cnt_q == CNT_FULL);

        // Gated by reset so a word being discarded never reaches the FIFO.
        wr_en    = (state_q == OUT_HOLD) && !i_fifo_full && !i_rst;

        // A word leaving this cycle frees the slot for the next word on the same edge.
        out_free = (state_q == OUT_EMPTY) || wr_en;

        // The count seen at the sampling edge decides: a byte meeting a full
        // accumulator is dropped even if that word moves out on this edge.
        accept    = i_rx_valid && !acc_full;
        drop      = i_rx_valid &&  acc_full;
        last_byte = accept && (cnt_q == CNT_LAST);

`ifdef UART_PACKER_TIMEOUT_FLUSH_EN
        partial = (cnt_q != '0) && !acc_full;
        // A byte arriving on the timeout edge takes priority over the flush.
        flush   = partial && !accept && (idle_q == IDLE_LAST);
`else
        flush   = 1'b0;
`endif

        // The completing byte (or a flush) moves straight to the output when it is
        // free, so back-to-back bytes keep flowing without a full-accumulator bubble.
        acc_done = acc_full || last_byte || flush;
        xfer     = acc_done && out_free;
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        acc_d   = acc_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        ovf_d   = ovf_q | drop;

        // Byte k of the word lands in lane k.
        for (int k = 0; k < BYTES; k++) begin
            if (accept && (cnt_q == cnt_t'(k))) begin
                acc_d[8*k +: 8] = i_rx_data;
            end
        end

        if (accept) begin
            cnt_d = cnt_q + cnt_t'(1);
        end

        // Unfilled lanes are already zero, so forcing the count is enough to pad.
        if (flush) begin
            cnt_d = CNT_FULL;
        end

        // The moved word includes a byte accepted on this same edge.
        if (xfer) begin
            out_d = acc_d;
            acc_d = '0;
            cnt_d = '0;
        end

        unique case (state_q)
            OUT_EMPTY: begin
                if (xfer) begin
                    state_d = OUT_HOLD;
                end
            end
            OUT_HOLD: begin
                // A write with a simultaneous refill keeps the slot occupied.
                if (wr_en && !xfer) begin
                    state_d = OUT_EMPTY;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

`ifdef UART_PACKER_TIMEOUT_FLUSH_EN
    // Idle counter runs only while a partial word is waiting.
    always_comb begin
        idle_d = idle_q;
        if (accept || !partial || flush) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + idle_t'(1);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            state_q <= OUT_EMPTY;
            ovf_q   <= 1'b0;
`ifdef UART_PACKER_TIMEOUT_FLUSH_EN
            idle_q  <= '0;
`endif
        end else begin
            acc_q   <= acc_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
`ifdef UART_PACKER_TIMEOUT_FLUSH_EN
            idle_q  <= idle_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_fifo_wr_en = wr_en;
    assign o_fifo_data  = out_q;
    assign o_overflow   = ovf_q;
    assign o_byte_cnt   = cnt_q;
    assign o_states     = {acc_full, (state_q == OUT_HOLD)};

endmodule
